// File: rtl/demux_pkg.sv
// Shared lane geometry and output vector types
// for the demux_bank routing channels.
package demux_pkg;

  localparam int W121 = 1;
  localparam int N121 = 2;
  localparam int S121 = 1;

  localparam int W124 = 4;
  localparam int N124 = 4;
  localparam int S124 = 2;

  localparam int W181 = 1;
  localparam int N181 = 8;
  localparam int S181 = 3;

  typedef logic [N121*W121-1:0] out121_t;
  typedef logic [N124*W124-1:0] out124_t;
  typedef logic [N181*W181-1:0] out181_t;

endpackage

// File: rtl/demux_lane.sv
// One registered 1:2^SEL_W demultiplexer channel;
// unselected lanes are forced to zero.
module demux_lane #(
  parameter int DATA_W = 1,
  parameter int SEL_W  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_W-1:0]              inData,
  input  logic [SEL_W-1:0]               inSel,
  output logic [(2**SEL_W)*DATA_W-1:0]   outData
);

  localparam int Lanes = 2**SEL_W;

  logic [Lanes*DATA_W-1:0] nxt;

  always_comb begin
    nxt = '0;
    for (int k = 0; k < Lanes; k++) begin
      if (inSel == SEL_W'(k)) begin
        nxt[k*DATA_W +: DATA_W] = inData;
      end
    end
  end

  // Whole vector loads at once: never a mix of old and new lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData <= '0;
    end else begin
      outData <= nxt;
    end
  end

endmodule

// File: rtl/demux_bank.sv
// Three independent registered demultiplexers
// sharing one clock and asynchronous reset.
module demux_bank
  import demux_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W121-1:0] in_data121,
  input  logic [S121-1:0] in_sel121,
  output out121_t         out_data121,
  input  logic [W124-1:0] in_data124,
  input  logic [S124-1:0] in_sel124,
  output out124_t         out_data124,
  input  logic [W181-1:0] in_data181,
  input  logic [S181-1:0] in_sel181,
  output out181_t         out_data181
);

  demux_lane #(
    .DATA_W (W121),
    .SEL_W  (S121)
  ) uCh121 (
    .clk     (clk),
    .rst_n   (rst_n),
    .inData  (in_data121),
    .inSel   (in_sel121),
    .outData (out_data121)
  );

  demux_lane #(
    .DATA_W (W124),
    .SEL_W  (S124)
  ) uCh124 (
    .clk     (clk),
    .rst_n   (rst_n),
    .inData  (in_data124),
    .inSel   (in_sel124),
    .outData (out_data124)
  );

  demux_lane #(
    .DATA_W (W181),
    .SEL_W  (S181)
  ) uCh181 (
    .clk     (clk),
    .rst_n   (rst_n),
    .inData  (in_data181),
    .inSel   (in_sel181),
    .outData (out_data181)
  );

endmodule

// File: tb/tb_demux_bank.sv
// Directed bench for demux_bank: reset, lane sweeps,
// simultaneous change and random run with mid-run reset.
module tb_demux_bank;

  logic        clk;
  logic        rst_n;
  logic        d121;
  logic        s121;
  logic [1:0]  o121;
  logic [3:0]  d124;
  logic [1:0]  s124;
  logic [15:0] o124;
  logic        d181;
  logic [2:0]  s181;
  logic [7:0]  o181;

  int checks = 0;
  int errors = 0;

  demux_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data121  (d121),
    .in_sel121   (s121),
    .out_data121 (o121),
    .in_data124  (d124),
    .in_sel124   (s124),
    .out_data124 (o124),
    .in_data181  (d181),
    .in_sel181   (s181),
    .out_data181 (o181)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] m121(logic d, logic s);
    return 2'(d) << s;
  endfunction

  function automatic logic [15:0] m124(logic [3:0] d, logic [1:0] s);
    return 16'(d) << (4 * s);
  endfunction

  function automatic logic [7:0] m181(logic d, logic [2:0] s);
    return 8'(d) << s;
  endfunction

  logic        rd121, rs121, rd181;
  logic [3:0]  rd124;
  logic [1:0]  rs124;
  logic [2:0]  rs181;

  initial begin
    rst_n = 1'b0;
    d121 = 1'b1; s121 = 1'b1;
    d124 = 4'hF; s124 = 2'd3;
    d181 = 1'b1; s181 = 3'd5;
    #2;
    chk("rst_init121", 16'(o121), 16'h0);
    chk("rst_init124", o124, 16'h0);
    chk("rst_init181", 16'(o181), 16'h0);
    tick();
    chk("rst_hold124", o124, 16'h0);
    rst_n = 1'b1;
    tick();
    chk("load121", 16'(o121), 16'h2);
    chk("load124", o124, 16'hF000);
    chk("load181", 16'(o181), 16'h20);

    // Asynchronous clear between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst121", 16'(o121), 16'h0);
    chk("arst124", o124, 16'h0);
    chk("arst181", 16'(o181), 16'h0);
    tick();
    rst_n = 1'b1;
    chk("arst_hold181", 16'(o181), 16'h0);

    // ch181 sweep
    d181 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s181 = 3'(i);
      tick();
      chk($sformatf("sw181_%0d", i), 16'(o181), 16'(8'h01 << i));
    end
    d181 = 1'b0;
    s181 = 3'd6;
    tick();
    chk("sw181_zero", 16'(o181), 16'h0);

    // ch124 select sweep then data sweep at lane 2
    d124 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      s124 = 2'(i);
      tick();
      chk($sformatf("sw124_sel%0d", i), o124, 16'h000A << (4 * i));
    end
    s124 = 2'd2;
    for (int i = 0; i < 16; i++) begin
      d124 = 4'(i);
      tick();
      chk($sformatf("sw124_dat%0d", i), o124, 16'(i) << 8);
    end

    // ch121
    d121 = 1'b1; s121 = 1'b0;
    tick();
    chk("c121_10", 16'(o121), 16'h1);
    s121 = 1'b1;
    tick();
    chk("c121_11", 16'(o121), 16'h2);
    d121 = 1'b0;
    tick();
    chk("c121_01", 16'(o121), 16'h0);
    s121 = 1'b0;
    tick();
    chk("c121_00", 16'(o121), 16'h0);

    // Simultaneous select and data change
    s124 = 2'd1; d124 = 4'h5;
    tick();
    chk("simul_a", o124, 16'h0050);
    s124 = 2'd3; d124 = 4'hC;
    #3;
    chk("simul_nocomb", o124, 16'h0050);
    tick();
    chk("simul_b", o124, 16'hC000);

    // Random run, reset pulse in the middle
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst124", o124, 16'h0);
        chk("mid_rst181", 16'(o181), 16'h0);
        tick();
        chk("mid_hold121", 16'(o121), 16'h0);
        rst_n = 1'b1;
      end
      rd121 = 1'($urandom); rs121 = 1'($urandom);
      rd124 = 4'($urandom); rs124 = 2'($urandom);
      rd181 = 1'($urandom); rs181 = 3'($urandom);
      d121 = rd121; s121 = rs121;
      d124 = rd124; s124 = rs124;
      d181 = rd181; s181 = rs181;
      tick();
      chk($sformatf("rnd121_%0d", i), 16'(o121), 16'(m121(rd121, rs121)));
      chk($sformatf("rnd124_%0d", i), o124, m124(rd124, rs124));
      chk($sformatf("rnd181_%0d", i), 16'(o181), 16'(m181(rd181, rs181)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
